// File: rtl/seven_seg_scan.sv
// Multiplexed four-digit common-anode seven-segment driver with a per-frame snapshot of the input.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always stays lit).
module seven_seg_scan #(
  parameter int REFRESH_DIV = 100_000,
  parameter int BLANK_CYC   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int            CW        = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   snap_val;
  logic [3:0]    snap_dp;
  logic          tick;
  logic [3:0]    nibble;
  logic [6:0]    seg_dec;
  logic          lit;
  logic          lead_blank;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  assign tick = (cnt == CNT_MAX);

  // The snapshot is taken on the last cycle of slot 3 so a whole frame always shows one value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      idx      <= '0;
      snap_val <= '0;
      snap_dp  <= '0;
    end else begin
      if (tick) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (tick && (idx == 2'd3)) begin
        snap_val <= value;
        snap_dp  <= dp_in;
      end
    end
  end

  assign nibble = snap_val[{idx, 2'b00} +: 4];

  always_comb begin
    seg_dec = 7'h7F;
    case (nibble)
      4'h0: seg_dec = 7'b1000000;
      4'h1: seg_dec = 7'b1111001;
      4'h2: seg_dec = 7'b0100100;
      4'h3: seg_dec = 7'b0110000;
      4'h4: seg_dec = 7'b0011001;
      4'h5: seg_dec = 7'b0010010;
      4'h6: seg_dec = 7'b0000010;
      4'h7: seg_dec = 7'b1111000;
      4'h8: seg_dec = 7'b0000000;
      4'h9: seg_dec = 7'b0010000;
      4'hA: seg_dec = 7'b0001000;
      4'hB: seg_dec = 7'b0000011;
      4'hC: seg_dec = 7'b1000110;
      4'hD: seg_dec = 7'b0100001;
      4'hE: seg_dec = 7'b0000110;
      4'hF: seg_dec = 7'b0001110;
      default: seg_dec = 7'h7F;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // zero_above[i] is set when nibbles i..3 are all zero; digit 0 is never blanked.
  logic [3:0] zero_above;
  always_comb begin
    zero_above    = 4'b0000;
    zero_above[3] = (snap_val[15:12] == 4'h0);
    zero_above[2] = zero_above[3] && (snap_val[11:8] == 4'h0);
    zero_above[1] = zero_above[2] && (snap_val[7:4] == 4'h0);
  end
  assign lead_blank = zero_above[idx];
`else
  assign lead_blank = 1'b0;
`endif

  assign lit = en && (cnt >= BLANK_END);

  // A blanked leading digit keeps its anode on only to show a requested decimal point.
  always_comb begin
    an_nxt  = 4'hF;
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    if (lit) begin
      if (!lead_blank) begin
        an_nxt  = ~(4'b0001 << idx);
        seg_nxt = seg_dec;
        dp_nxt  = ~snap_dp[idx];
      end else if (snap_dp[idx]) begin
        an_nxt = ~(4'b0001 << idx);
        dp_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= 4'hF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan: table of display vectors plus reset, tearing,
// enable and hex-decode sequences; expected per-edge outputs are queued and checked at negedge.
module tb_seven_seg_scan;

  localparam int RDIV  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * RDIV;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  typedef struct {
    int         ecount;
    string      tag;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [27:0] segs;
    logic [3:0]  lzb;
  } vec_t;

  exp_t       sbq[$];
  exp_t       mon_x;
  vec_t       vecs[8];
  logic [6:0] hex_seg[16];
  logic [3:0] an_tab[4];
  logic [27:0] abcd_segs;
  logic [27:0] zero_segs;
  int         e;
  int         n_tests = 0;
  int         n_fail  = 0;

  seven_seg_scan #(.REFRESH_DIV(RDIV), .BLANK_CYC(BLANK)) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .dp_in (dp_in),
    .en    (en),
    .seg   (seg),
    .dp    (dp),
    .an    (an)
  );

  always #5 clk = ~clk;

  // Active clock edges since the last reset release; output after edge e reflects slot position e-1.
  always @(posedge clk or negedge rst) begin
    if (!rst) e <= 0;
    else      e <= e + 1;
  end

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].ecount <= e) begin
      mon_x = sbq.pop_front();
      n_tests++;
      if (mon_x.ecount != e || an !== mon_x.an || seg !== mon_x.seg || dp !== mon_x.dp) begin
        n_fail++;
        $display("[TB] FAIL %s edge=%0d(at %0d) got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 mon_x.tag, mon_x.ecount, e, an, seg, dp, mon_x.an, mon_x.seg, mon_x.dp);
      end
    end
  end

  task automatic apply_stimulus(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
  endtask

  task automatic check_output(input string tag, input logic [3:0] xan, input logic [6:0] xseg,
                              input logic xdp);
    n_tests++;
    if (an !== xan || seg !== xseg || dp !== xdp) begin
      n_fail++;
      $display("[TB] FAIL %s got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
               tag, an, seg, dp, xan, xseg, xdp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue one frame of expectations; positions gap_lo..gap_hi-1 are the cycles seen with en=0.
  task automatic push_frame(input int first_edge, input string tag, input logic [27:0] segs,
                            input logic [3:0] dps, input logic [3:0] lzb,
                            input int gap_lo, input int gap_hi);
    exp_t x;
    int   slot;
    int   c;
    for (int k = 0; k < FRAME; k++) begin
      slot     = k / RDIV;
      c        = k % RDIV;
      x.ecount = first_edge + k;
      x.tag    = tag;
      x.an     = 4'hF;
      x.seg    = 7'h7F;
      x.dp     = 1'b1;
      if (c >= BLANK && !(k >= gap_lo && k < gap_hi)) begin
        if (!lzb[slot]) begin
          x.an  = an_tab[slot];
          x.seg = segs[7*slot +: 7];
          x.dp  = ~dps[slot];
        end else if (dps[slot]) begin
          x.an = an_tab[slot];
          x.dp = 1'b0;
        end
      end
      sbq.push_back(x);
    end
  endtask

  initial begin
    hex_seg[0]  = 7'b1000000; hex_seg[1]  = 7'b1111001; hex_seg[2]  = 7'b0100100;
    hex_seg[3]  = 7'b0110000; hex_seg[4]  = 7'b0011001; hex_seg[5]  = 7'b0010010;
    hex_seg[6]  = 7'b0000010; hex_seg[7]  = 7'b1111000; hex_seg[8]  = 7'b0000000;
    hex_seg[9]  = 7'b0010000; hex_seg[10] = 7'b0001000; hex_seg[11] = 7'b0000011;
    hex_seg[12] = 7'b1000110; hex_seg[13] = 7'b0100001; hex_seg[14] = 7'b0000110;
    hex_seg[15] = 7'b0001110;
    an_tab[0] = 4'b1110; an_tab[1] = 4'b1101; an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;

    abcd_segs = {hex_seg[10], hex_seg[11], hex_seg[12], hex_seg[13]};
    zero_segs = {hex_seg[0], hex_seg[0], hex_seg[0], hex_seg[0]};

    vecs[0] = '{16'h1234, 4'b0100, {hex_seg[1], hex_seg[2], hex_seg[3], hex_seg[4]}, 4'b0000};
    vecs[1] = vecs[0];
    vecs[2] = '{16'hABCD, 4'b0000, abcd_segs, 4'b0000};
    vecs[3] = '{16'h8E5F, 4'b1010, {hex_seg[8], hex_seg[14], hex_seg[5], hex_seg[15]}, 4'b0000};
    vecs[4] = '{16'h0042, 4'b0001, {hex_seg[0], hex_seg[0], hex_seg[4], hex_seg[2]},
                LZB ? 4'b1100 : 4'b0000};
    vecs[5] = '{16'h0000, 4'b0000, zero_segs, LZB ? 4'b1110 : 4'b0000};
    vecs[6] = '{16'h0000, 4'b1000, zero_segs, LZB ? 4'b1110 : 4'b0000};
    vecs[7] = '{16'h0100, 4'b0010, {hex_seg[0], hex_seg[1], hex_seg[0], hex_seg[0]},
                LZB ? 4'b1000 : 4'b0000};

    value = 16'hFFFF;
    dp_in = 4'b0000;
    en    = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check_output("reset_hold", 4'hF, 7'h7F, 1'b1);
    end
    rst = 1'b1;

    // Frame 0 shows the reset snapshot; each table vector appears one frame after it is driven.
    push_frame(1, "frame0", zero_segs, 4'b0000, LZB ? 4'b1110 : 4'b0000, 0, 0);
    for (int r = 0; r < 8; r++) begin
      apply_stimulus(vecs[r].value, vecs[r].dp_in);
      push_frame(e + FRAME + 1, $sformatf("vec%0d", r), vecs[r].segs, vecs[r].dp_in,
                 vecs[r].lzb, 0, 0);
      wait_edges(FRAME);
    end

    apply_stimulus(16'h1234, 4'b0100);
    push_frame(e + FRAME + 1, "tear_old", vecs[0].segs, 4'b0100, 4'b0000, 0, 0);
    wait_edges(FRAME);
    push_frame(e + FRAME + 1, "tear_new", abcd_segs, 4'b0000, 4'b0000, 0, 0);
    wait_edges(10);
    apply_stimulus(16'hABCD, 4'b0000);
    wait_edges(FRAME - 10);
    wait_edges(FRAME);

    push_frame(e + 1, "enable", abcd_segs, 4'b0000, 4'b0000, 10, 15);
    wait_edges(10);
    en = 1'b0;
    wait_edges(5);
    en = 1'b1;
    wait_edges(FRAME - 15);

    for (int n = 0; n < 16; n++) begin
      apply_stimulus(16'(n), 4'b0000);
      push_frame(e + FRAME + 1, $sformatf("hex%0h", n),
                 {hex_seg[0], hex_seg[0], hex_seg[0], hex_seg[n]}, 4'b0000,
                 LZB ? 4'b1110 : 4'b0000, 0, 0);
      wait_edges(FRAME);
    end
    wait_edges(FRAME);

    // Reset asserted in the middle of slot 2 while that digit is lit.
    wait_edges(2 * RDIV + 4);
    check_output("pre_reset", LZB ? 4'hF : 4'b1011, LZB ? 7'h7F : hex_seg[0], 1'b1);
    rst = 1'b0;
    #1;
    check_output("reset_async", 4'hF, 7'h7F, 1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
      check_output("reset_mid", 4'hF, 7'h7F, 1'b1);
    end
    rst = 1'b1;
    push_frame(1, "post_reset", zero_segs, 4'b0000, LZB ? 4'b1110 : 4'b0000, 0, 0);
    wait_edges(FRAME);
    @(negedge clk);
    #1;

    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL queue_drain got %0d pending want 0", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Multiplexed four-digit seven-segment display driver, the output-side counterpart to the board's pushbutton input conditioning chain. It takes a 16-bit hexadecimal value, four decimal-point bits and an enable, all in the system clock domain, and time-multiplexes them onto common-anode digit strobes. It sits at the top level between the application datapath and the board's seg/dp/an pins. All outputs are active-low and registered.

## Interface
- REFRESH_DIV, 100_000 — clock cycles per digit slot. Must be ≥ 4.
- BLANK_CYC, 16 — cycles at the start of each slot during which all anodes are held off (anti-ghosting). Must be < REFRESH_DIV.
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- value  input  16  four hex nibbles; nibble i drives digit i; digit 0 is rightmost
- dp_in  input  4  decimal point per digit, active-high request
- en  input  1  display enable; 0 blanks the outputs while the counters keep running
- seg  output  7  {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- an  output  4  digit anodes, active-low, one-hot-low while lit

## Operation
- Prescaler `cnt` counts 0..REFRESH_DIV-1 and wraps. `tick` = (cnt == REFRESH_DIV-1).
- Digit index `idx` (2 bits) increments on tick and wraps 3→0.
- Frame snapshot: on the cycle where tick && idx==3, `value` and `dp_in` are captured into `snap_val`/`snap_dp`. Input changes are therefore visible only from the next frame (no tearing).
- Decode (active-low) of snap_val nibble[idx]:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Digit lit when en=1 and cnt ≥ BLANK_CYC. While lit: an = ~(1<<idx), seg = decode, dp = ~snap_dp[idx]. Otherwise an=4'hF, seg=7'h7F, dp=1.
- en has no effect on cnt, idx or snapshot timing.
- Reset: while rst=0, cnt=0, idx=0, snap_val=0, snap_dp=0, an=4'hF, seg=7'h7F, dp=1. Assertion takes effect immediately, mid-slot included. After release, the first frame displays 0 until the first snapshot.

## Timing
- All outputs are registered from the current cnt/idx/snap/en. Each output lags its cause by exactly 1 clock.
- Slot for digit i: REFRESH_DIV cycles. an is off for the first BLANK_CYC of those cycles and on for the remaining REFRESH_DIV-BLANK_CYC cycles.
- Frame = 4·REFRESH_DIV cycles.
- en change: outputs respond on the next clock edge.
- A snapshot taken at the tick ending slot 3 is used starting with slot 0 of the next frame. seg for digit 0 shows the new value in the first lit cycle of that slot.

## Configuration
- LEADING_ZERO_BLANK_EN defined: a slot idx>0 is treated as unlit when snap_val nibbles idx..3 are all zero. Its dp still lights if snap_dp[idx]=1; in that case an is active and seg=7'h7F. Digit 0 is always lit.
- Not defined: all four digits are always lit, leading zeros included.

## Test plan
Bench parameters: REFRESH_DIV=8, BLANK_CYC=2.
- Reset: hold rst=0 for 5 cycles with value=16'hFFFF and en=1 -> an=4'hF, seg=7'h7F, dp=1 throughout. Assert rst mid-slot 2 -> outputs at reset values immediately, and idx=0 after release.
- Scan: value=16'h1234, dp_in=4'b0100, en=1, run 2 frames -> second frame shows:
  - an=1110/seg=0011001
  - an=1101/seg=0110000
  - an=1011/seg=0100100, dp=0
  - an=0111/seg=1111001
  - each digit lit for 6 cycles and dark for 2 cycles.
- Tearing: change value from 16'h1234 to 16'hABCD during slot 1 -> remaining slots of that frame still show 1234; the next frame shows d, C, b, A (0100001, 1000110, 0000011, 0001000).
- Enable: drop en for 5 cycles mid-slot -> an=4'hF one cycle later. Restore en -> lighting resumes with idx unaffected by the gap.
- Hex decode: step through value nibble 0..F on digit 0 across 16 frames -> seg matches the decode table for every value.
- LEADING_ZERO_BLANK_EN:
  - value=16'h0042 -> slots 2 and 3 have an=4'hF.
  - value=16'h0000 -> only digit 0 lit, with seg=1000000.
  - value=16'h0000 with dp_in=4'b1000 -> slot 3 shows an=0111, seg=7'h7F, dp=0.
